// File: rtl/ram_arbiter_if.sv
// Bundle of the two requester ports, the clear controls and the RAM port
// that the arbiter drives.
interface ram_arbiter_if #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 4
);
  logic              a_req;
  logic              a_we;
  logic [AWIDTH-1:0] a_addr;
  logic [DWIDTH-1:0] a_wdata;
  logic              a_ack;
  logic [DWIDTH-1:0] a_rdata;

  logic              b_req;
  logic              b_we;
  logic [AWIDTH-1:0] b_addr;
  logic [DWIDTH-1:0] b_wdata;
  logic              b_ack;
  logic [DWIDTH-1:0] b_rdata;

  logic              clr;
  logic              clr_busy;
  logic              clr_done;

  logic              ram_wen;
  logic [AWIDTH-1:0] ram_addr;
  logic [DWIDTH-1:0] ram_din;
  logic [DWIDTH-1:0] ram_dout;

  // Environment side: requesters, clear source and the RAM's read port.
  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_ack, a_rdata,
    output b_req, b_we, b_addr, b_wdata,
    input  b_ack, b_rdata,
    output clr,
    input  clr_busy, clr_done,
    input  ram_wen, ram_addr, ram_din,
    output ram_dout
  );

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_ack, a_rdata,
    input  b_req, b_we, b_addr, b_wdata,
    output b_ack, b_rdata,
    input  clr,
    output clr_busy, clr_done,
    output ram_wen, ram_addr, ram_din,
    input  ram_dout
  );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter for two requesters sharing one single-port RAM, plus a
// bulk-clear sweep that writes FILL to every address.
module ram_arbiter #(
  parameter int                DWIDTH = 16,
  parameter int                AWIDTH = 4,
  parameter logic [DWIDTH-1:0] FILL   = '0
) (
  input logic          clk,
  input logic          rst,
  ram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    CLEAR
  } state_t;

  state_t            state, state_n;

  logic              ptr_b;      // 1 = B wins a tie
  logic              own_b;      // requester that owns the current access
  logic              lat_we;
  logic [AWIDTH-1:0] lat_addr;
  logic [DWIDTH-1:0] lat_wdata;
  logic              clr_pend;
  logic [AWIDTH-1:0] cnt;

  logic              a_elig, b_elig;
  logic              grant_b;
  logic              clr_go;
  logic              sweep_last;

  // A req still high during its own ack cycle belongs to the finished request.
  assign a_elig     = bus.a_req && !bus.a_ack;
  assign b_elig     = bus.b_req && !bus.b_ack;
  assign grant_b    = b_elig && (!a_elig || ptr_b);
  assign clr_go     = clr_pend || bus.clr;
  assign sweep_last = (cnt == {AWIDTH{1'b1}});

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block or statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (clr_go)                state_n = CLEAR;
        else if (a_elig || b_elig) state_n = ACCESS;
      end
      ACCESS:  state_n = IDLE;
      CLEAR:   if (sweep_last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    bus.ram_wen  = 1'b0;
    bus.ram_addr = '0;
    bus.ram_din  = '0;
    unique case (state)
      ACCESS: begin
        bus.ram_wen  = lat_we;
        bus.ram_addr = lat_addr;
        bus.ram_din  = lat_wdata;
      end
      CLEAR: begin
        bus.ram_wen  = 1'b1;
        bus.ram_addr = cnt;
        bus.ram_din  = FILL;
      end
      default: ;
    endcase
    // Reset must never commit a write, even mid-access or mid-sweep.
    if (rst) bus.ram_wen = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_b        <= 1'b0;
      own_b        <= 1'b0;
      lat_we       <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      clr_pend     <= 1'b0;
      cnt          <= '0;
      bus.a_ack    <= 1'b0;
      bus.b_ack    <= 1'b0;
      bus.a_rdata  <= '0;
      bus.b_rdata  <= '0;
      bus.clr_busy <= 1'b0;
      bus.clr_done <= 1'b0;
    end else begin
      bus.a_ack    <= 1'b0;
      bus.b_ack    <= 1'b0;
      bus.clr_done <= 1'b0;

      if (state != CLEAR && bus.clr) clr_pend <= 1'b1;

      unique case (state)
        IDLE: begin
          if (clr_go) begin
            clr_pend     <= 1'b0;
            cnt          <= '0;
            bus.clr_busy <= 1'b1;
          end else if (a_elig || b_elig) begin
            own_b     <= grant_b;
            ptr_b     <= !grant_b;
            lat_we    <= grant_b ? bus.b_we    : bus.a_we;
            lat_addr  <= grant_b ? bus.b_addr  : bus.a_addr;
            lat_wdata <= grant_b ? bus.b_wdata : bus.a_wdata;
          end
        end
        ACCESS: begin
          if (own_b) begin
            bus.b_ack <= 1'b1;
            if (!lat_we) bus.b_rdata <= bus.ram_dout;
          end else begin
            bus.a_ack <= 1'b1;
            if (!lat_we) bus.a_rdata <= bus.ram_dout;
          end
        end
        CLEAR: begin
          if (sweep_last) begin
            cnt          <= '0;
            bus.clr_busy <= 1'b0;
            bus.clr_done <= 1'b1;
          end else begin
            cnt <= cnt + AWIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 16x16 RAM behind it.
module tb_ram_arbiter;

  localparam int          DW   = 16;
  localparam int          AW   = 4;
  localparam logic [15:0] FILL = 16'h00AA;

  // Contention table: per cycle after both requests are sampled.
  localparam logic [3:0] CON_ADDR [8] = '{4'd5, 4'd0, 4'd3, 4'd0, 4'd5, 4'd0, 4'd3, 4'd0};
  localparam logic       CON_AACK [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam logic       CON_BACK [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  logic clk;
  logic rst;
  logic preload;
  int   vectors;
  int   miscompares;

  ram_arbiter_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

  ram_arbiter #(.DWIDTH(DW), .AWIDTH(AW), .FILL(FILL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // RAM model: synchronous write, combinational read, preload word i = i+1.
  logic [DW-1:0] mem [2**AW];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 2**AW; i++) mem[i] <= DW'(i + 1);
    end else if (bus.ram_wen) begin
      mem[bus.ram_addr] <= bus.ram_din;
    end
  end
  assign bus.ram_dout = mem[bus.ram_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One isolated access from IDLE: ACCESS cycle, ack cycle, stale-req cycle.
  task automatic access(input bit port_b, input bit we, input logic [3:0] addr,
                        input logic [15:0] wdata, input logic [15:0] exp_rd,
                        input string tag);
    if (port_b) begin
      bus.b_req = 1'b1; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wdata;
    end else begin
      bus.a_req = 1'b1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wdata;
    end
    tick();
    check({tag, ".addr"}, bus.ram_addr, addr);
    check({tag, ".wen"},  bus.ram_wen,  we);
    check({tag, ".din"},  bus.ram_din,  wdata);
    tick();
    check({tag, ".ack"},   port_b ? bus.b_ack   : bus.a_ack,   1);
    check({tag, ".rdata"}, port_b ? bus.b_rdata : bus.a_rdata, exp_rd);
    check({tag, ".other"}, port_b ? bus.a_ack   : bus.b_ack,   0);
    tick();
    if (port_b) bus.b_req = 1'b0;
    else        bus.a_req = 1'b0;
    check({tag, ".ackdrop"}, port_b ? bus.b_ack : bus.a_ack, 0);
    check({tag, ".noregrant"}, bus.ram_addr, 0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    preload     = 1'b1;
    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;
    bus.clr   = 1'b0;
    tick();
    preload = 1'b0;
    tick();

    // Reset state
    check("rst.a_ack",    bus.a_ack,    0);
    check("rst.b_ack",    bus.b_ack,    0);
    check("rst.a_rdata",  bus.a_rdata,  0);
    check("rst.b_rdata",  bus.b_rdata,  0);
    check("rst.busy",     bus.clr_busy, 0);
    check("rst.done",     bus.clr_done, 0);
    check("rst.wen",      bus.ram_wen,  0);
    check("rst.addr",     bus.ram_addr, 0);
    rst = 1'b0;

    // Single read, write then read back, neighbour untouched
    access(1'b0, 1'b0, 4'd5, 16'h0000, 16'h0006, "rdA5");
    access(1'b1, 1'b1, 4'd3, 16'hBEEF, 16'h0000, "wrB3");
    access(1'b1, 1'b0, 4'd3, 16'h0000, 16'hBEEF, "rdB3");
    access(1'b1, 1'b0, 4'd2, 16'h0000, 16'h0003, "rdB2");

    // Reset returns the pointer to A and clears the read registers
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2.a_rdata", bus.a_rdata, 0);
    check("rst2.b_rdata", bus.b_rdata, 0);

    // Contention: both held, grants A,B,A,B with an ack every 2 cycles
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 4'd5;
    bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 4'd3;
    for (int c = 0; c < 8; c++) begin
      tick();
      check("con.addr",  bus.ram_addr, CON_ADDR[c]);
      check("con.a_ack", bus.a_ack,    CON_AACK[c]);
      check("con.b_ack", bus.b_ack,    CON_BACK[c]);
      if (c == 6) bus.a_req = 1'b0;
      if (c == 7) bus.b_req = 1'b0;
    end
    check("con.a_rdata", bus.a_rdata, 16'h0006);
    check("con.b_rdata", bus.b_rdata, 16'hBEEF);
    tick();
    check("con.idle_addr", bus.ram_addr, 0);
    check("con.idle_wen",  bus.ram_wen,  0);

    // Clear sweep; a second clr mid-sweep is ignored
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    for (int k = 0; k < 16; k++) begin
      check("clr.wen",  bus.ram_wen,  1);
      check("clr.addr", bus.ram_addr, k);
      check("clr.din",  bus.ram_din,  FILL);
      check("clr.busy", bus.clr_busy, 1);
      check("clr.done", bus.clr_done, 0);
      if (k == 3) bus.clr = 1'b1;
      if (k == 4) bus.clr = 1'b0;
      tick();
    end
    check("clr.done_pulse", bus.clr_done, 1);
    check("clr.busy_drop",  bus.clr_busy, 0);
    check("clr.wen_drop",   bus.ram_wen,  0);
    tick();
    check("clr.done_end",   bus.clr_done, 0);
    check("clr.no_resweep", bus.ram_wen,  0);
    access(1'b0, 1'b0, 4'd0,  16'h0000, FILL, "fillA0");
    access(1'b0, 1'b0, 4'd7,  16'h0000, FILL, "fillA7");
    access(1'b0, 1'b0, 4'd15, 16'h0000, FILL, "fillA15");

    // clr during ACCESS: access completes, then sweep; B waits through it
    access(1'b0, 1'b1, 4'd9, 16'h1234, FILL, "wrA9");
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 4'd9;
    tick();
    check("col.addr", bus.ram_addr, 4'd9);
    bus.clr   = 1'b1;
    bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 4'd9;
    tick();
    bus.clr = 1'b0;
    check("col.a_ack",   bus.a_ack,    1);
    check("col.a_rdata", bus.a_rdata,  16'h1234);
    check("col.busy0",   bus.clr_busy, 0);
    tick();
    bus.a_req = 1'b0;
    check("col.busy1", bus.clr_busy, 1);
    check("col.wen",   bus.ram_wen,  1);
    check("col.addr0", bus.ram_addr, 0);
    for (int k = 1; k < 16; k++) begin
      tick();
      check("col.addr_k",  bus.ram_addr, k);
      check("col.b_wait",  bus.b_ack,    0);
    end
    tick();
    check("col.done",     bus.clr_done, 1);
    check("col.b_notyet", bus.b_ack,    0);
    tick();
    check("col.b_addr", bus.ram_addr, 4'd9);
    check("col.b_wen",  bus.ram_wen,  0);
    tick();
    bus.b_req = 1'b0;
    check("col.b_ack",   bus.b_ack,   1);
    check("col.b_rdata", bus.b_rdata, FILL);
    tick();
    check("col.b_ackdrop", bus.b_ack, 0);

    // Reset at counter = 8 aborts the sweep
    preload = 1'b1;
    tick();
    preload = 1'b0;
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    for (int k = 0; k < 9; k++) begin
      check("abort.addr", bus.ram_addr, k);
      if (k < 8) tick();
    end
    rst = 1'b1;
    #1;
    check("abort.wen_forced", bus.ram_wen, 0);
    tick();
    check("abort.busy",    bus.clr_busy, 0);
    check("abort.done",    bus.clr_done, 0);
    check("abort.wen",     bus.ram_wen,  0);
    check("abort.addr0",   bus.ram_addr, 0);
    check("abort.din",     bus.ram_din,  0);
    check("abort.a_ack",   bus.a_ack,    0);
    check("abort.b_ack",   bus.b_ack,    0);
    check("abort.a_rdata", bus.a_rdata,  0);
    check("abort.b_rdata", bus.b_rdata,  0);
    rst = 1'b0;
    tick();
    check("abort.no_done", bus.clr_done, 0);
    access(1'b0, 1'b0, 4'd0,  16'h0000, FILL,     "abA0");
    access(1'b0, 1'b0, 4'd7,  16'h0000, FILL,     "abA7");
    access(1'b0, 1'b0, 4'd8,  16'h0000, 16'h0009, "abA8");
    access(1'b0, 1'b0, 4'd15, 16'h0000, 16'h0010, "abA15");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester arbiter and clear sequencer for the single-port `RAM` block (DWIDTH-bit words, 2**AWIDTH deep, synchronous write, combinational read). It shares the one RAM port between requesters A and B with round-robin priority and a req/ack handshake. It also runs a bulk-clear sweep that writes a fill value to every address. It sits directly in front of the RAM instance and is the only driver of the RAM's `wen`, `addr` and `din`.

## Interface
- `DWIDTH`, 16, data word width; must equal the RAM's DWIDTH.
- `AWIDTH`, 4, address width; the RAM depth is 2**AWIDTH.
- `FILL`, 0, DWIDTH-bit value written by the clear sweep.

- `clk`  in  1  single clock; everything is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `a_req`, `b_req`  in  1  request; held with its fields stable until the matching ack.
- `a_we`, `b_we`  in  1  1 = write, 0 = read.
- `a_addr`, `b_addr`  in  AWIDTH  access address.
- `a_wdata`, `b_wdata`  in  DWIDTH  write data.
- `a_ack`, `b_ack`  out  1  one-cycle completion pulse.
- `a_rdata`, `b_rdata`  out  DWIDTH  read result; valid while ack is high, held until the next read ack to that port.
- `clr`  in  1  single-cycle pulse that requests a clear sweep.
- `clr_busy`  out  1  high for the whole sweep.
- `clr_done`  out  1  one-cycle pulse after the last fill write.
- `ram_wen`  out  1  RAM write enable.
- `ram_addr`  out  AWIDTH  RAM address.
- `ram_din`  out  DWIDTH  RAM write data.
- `ram_dout`  in  DWIDTH  RAM combinational read data.

## Operation
- States:
  - IDLE: no RAM activity; evaluates clear and requests.
  - ACCESS: performs one granted access.
  - CLEAR: runs the fill sweep.
- IDLE transitions, in priority order:
  - pending clear -> CLEAR;
  - otherwise an eligible request -> ACCESS;
  - otherwise stay in IDLE.
- A request is eligible when its req is high and its ack is not high in the same cycle. A req seen in the ack cycle is the stale tail of the completed request.
- Arbitration:
  - A priority pointer picks the winner when both A and B are eligible.
  - After each grant, the pointer moves to the other requester.
  - Reset sets the pointer to A.
  - A lone eligible requester wins regardless of the pointer.
- On grant, the winner's `we`, `addr` and `wdata` are latched into internal registers, and the owner is recorded.
- ACCESS:
  - `ram_addr` = latched address, `ram_din` = latched write data, `ram_wen` = latched we.
  - At the end of ACCESS, a read captures `ram_dout` into the owner's rdata register.
  - A write leaves that register unchanged.
  - The owner's ack is set and the state returns to IDLE.
- CLEAR:
  - A counter runs 0 .. 2**AWIDTH-1, one address per cycle.
  - `ram_wen`=1, `ram_addr`=counter, `ram_din`=FILL.
  - After the last address: `clr_done` pulses, `clr_busy` drops, state returns to IDLE.
- Clear handling:
  - `clr` seen in any state other than CLEAR sets a pending flag, which IDLE services. In ACCESS this means after the current access.
  - `clr` during CLEAR is ignored.
  - Requests arriving during CLEAR wait; they are not acked and not lost.
- Outside ACCESS and CLEAR: `ram_wen`=0, `ram_addr`=0, `ram_din`=0.
- `ram_wen` is forced to 0 while `rst` is high.
- Reset:
  - Values: state IDLE; `a_ack`/`b_ack` 0; `a_rdata`/`b_rdata` 0; `clr_busy` 0; `clr_done` 0; pending clear cleared; counter 0; pointer A.
  - RAM contents are not touched by reset.
  - Reset during ACCESS or CLEAR aborts immediately: no ack and no `clr_done`. Fill writes already done remain in the RAM.

## Timing
- Access latency:
  - req sampled in IDLE at edge T;
  - ACCESS during cycle T+1; the write commits at edge T+2;
  - ack and rdata visible in cycle T+2.
- In the ack cycle the arbiter may grant the other requester, so aggregate throughput is one access per 2 cycles.
- Per-requester throughput is one access per 3 cycles.
- Read-during-clear is not possible: accesses and the sweep are mutually exclusive by state.
- Clear:
  - `clr` at edge T with the block in IDLE: CLEAR begins in cycle T+1 and writes address k in cycle T+1+k.
  - `clr_busy` is high in cycles T+1 .. T+2**AWIDTH.
  - `clr_done` pulses in cycle T+2**AWIDTH+1.
- `clr` arriving in the same cycle as an eligible request: clear wins, and the request is served after the sweep.

## Test plan
- Read A: the RAM powers up with word i = i+1. A reads addr 5 -> `a_ack` one pulse 2 cycles after req sampled, `a_rdata`=6, `ram_wen` never high.
- Write then read: B writes 0xBEEF to addr 3, then B reads addr 3 -> second `b_ack` with `b_rdata`=0xBEEF; addr 2 still reads 3.
- Contention: A and B request in the same cycle, both holding req for repeated accesses -> grant order after reset is A,B,A,B; acks alternate every 2 cycles; neither port is starved.
- Clear: FILL=0x00AA, `clr` pulse -> 16 consecutive `ram_wen` cycles at addr 0..15, `clr_busy` high for 16 cycles, `clr_done` 1 pulse; reads of addrs 0, 7 and 15 then return 0x00AA.
- Clear collisions: `clr` during ACCESS -> the access acks normally, then the sweep starts. A request held during the sweep is acked only after `clr_done`, with post-fill data.
- Reset mid-sweep: `rst` at counter=8 -> no `clr_done`; all outputs 0 next cycle; addr 0..7 read FILL and addr 8..15 keep prior data.
